router_input_buffer: RTL

- Parametrised next-generation router input stage: two virtual channels (VC0 even, VC1 odd), each a DEPTH-entry FIFO instead of a single register.
- Explicit occupancy counters replace "zero word means empty", so all-zero flits are legal data.
- Registered valid/data output toward the crossbar; sits between a link receiver and the router's route/arbitration logic.
- Polarity selects the VC written this cycle; the opposite VC is drained.

---
 rtl/router_input_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/router_input_buffer.sv
// Two-VC router input stage: per-VC DEPTH-entry FIFOs with occupancy counters, registered output.
// Optional `ROUTER_INPUT_BUFFER_OCC_EN adds vc0_count/vc1_count and almost_full outputs.
module router_input_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         polarity,
  input  logic                         send,
  input  logic                         blocked,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         drop_err
`ifdef ROUTER_INPUT_BUFFER_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   vc0_count,
  output logic [$clog2(DEPTH+1)-1:0]   vc1_count,
  output logic                         almost_full
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0]         wptr_q [2];
  logic [PW-1:0]         rptr_q [2];
  logic [CW-1:0]         cnt_q  [2];

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  drop_err_q, drop_err_d;

  logic wvc, rvc, push, pop, refuse;

  assign wvc    = polarity;
  assign rvc    = ~polarity;
  assign ready  = reset && !blocked && (cnt_q[wvc] != FULL);
  assign push   = send && ready;
  assign pop    = reset && !blocked && (cnt_q[rvc] != '0);
  assign refuse = reset && send && !ready;

  always_comb begin
    out_valid_d = pop;
    data_out_d  = '0;
    if (pop) data_out_d = mem_q[rvc][rptr_q[rvc]];
    drop_err_d  = drop_err_q || refuse;
  end

  // Array storage is not reset; occupancy counters alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wvc][wptr_q[wvc]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned v = 0; v < 2; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      // Push and pop always hit opposite VCs, so each count moves by at most one.
      if (push) begin
        wptr_q[wvc] <= wptr_q[wvc] + 1'b1;
        cnt_q[wvc]  <= cnt_q[wvc] + 1'b1;
      end
      if (pop) begin
        rptr_q[rvc] <= rptr_q[rvc] + 1'b1;
        cnt_q[rvc]  <= cnt_q[rvc] - 1'b1;
      end
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign drop_err  = drop_err_q;

`ifdef ROUTER_INPUT_BUFFER_OCC_EN
  assign vc0_count   = cnt_q[0];
  assign vc1_count   = cnt_q[1];
  assign almost_full = reset && (cnt_q[wvc] >= CW'(DEPTH - 1));
`endif

endmodule
